// File: rtl/regfile_exec.sv
// Execute/write-back stage: four general registers, single-cycle ALU and shift-add multiplier.
// Optional build macro REGFILE_EXEC_R0_ZERO_EN hardwires R0 to zero and drops writes to it.
module regfile_exec #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         opcode,
  input  logic [1:0]         dst,
  input  logic [2*WIDTH-1:0] opts,
  output logic               busy,
  output logic               done,
  output logic               zf,
  output logic               cf,
  output logic [WIDTH-1:0]   R0,
  output logic [WIDTH-1:0]   R1,
  output logic [WIDTH-1:0]   R2,
  output logic [WIDTH-1:0]   R3
);

  // state  | meaning
  // S_IDLE | waiting for start; operands latched on accept
  // S_EXEC | single-cycle ALU result captured, or multiplier initialised
  // S_MUL  | shift-add, one multiplier bit per cycle, LSB first
  // S_WB   | result written to R[dst], flags updated, done pulsed
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WB} state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam int CW = $clog2(WIDTH + 1);

  state_t               r_state;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [3:0]           r_op;
  logic [1:0]           r_dst;
  logic [WIDTH-1:0]     r_res;
  logic                 r_cf;
  logic [2*WIDTH-1:0]   r_prod;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_regs [4];

  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_res;
  logic                 w_cf;
  logic [2*WIDTH-1:0]   w_prod_nxt;

  assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff     = {1'b0, r_a} - {1'b0, r_b};
  assign w_prod_nxt = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

  always_comb begin
    w_res = '0;
    w_cf  = 1'b0;
    case (r_op)
      OP_ADD: begin w_res = w_sum[WIDTH-1:0];  w_cf = w_sum[WIDTH];  end
      OP_SUB: begin w_res = w_diff[WIDTH-1:0]; w_cf = w_diff[WIDTH]; end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_NOT: w_res = ~r_a;
      OP_MOV: w_res = r_b;
      OP_SHL: begin w_res = r_a << 1; w_cf = r_a[WIDTH-1]; end
      OP_SHR: begin w_res = r_a >> 1; w_cf = r_a[0];       end
      default: begin w_res = '0; w_cf = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_dst    <= '0;
      r_res    <= '0;
      r_cf     <= 1'b0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      done     <= 1'b0;
      zf       <= 1'b0;
      cf       <= 1'b0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= opts[2*WIDTH-1:WIDTH];
            r_b     <= opts[WIDTH-1:0];
            r_op    <= opcode;
            r_dst   <= dst;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_op == OP_MUL) begin
            r_prod   <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, r_a};
            r_mplier <= r_b;
            r_cnt    <= CW'(WIDTH);
            r_state  <= S_MUL;
          end else begin
            r_res   <= w_res;
            r_cf    <= w_cf;
            r_state <= S_WB;
          end
        end
        S_MUL: begin
          r_prod   <= w_prod_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_res    <= w_prod_nxt[WIDTH-1:0];
          r_cf     <= |w_prod_nxt[2*WIDTH-1:WIDTH];
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= S_WB;
        end
        S_WB: begin
          done    <= 1'b1;
          r_state <= S_IDLE;
          // opcodes above MUL are NOPs: no write, flags hold
          if (r_op <= OP_MUL) begin
`ifdef REGFILE_EXEC_R0_ZERO_EN
            if (r_dst != 2'd0) r_regs[r_dst] <= r_res;
`else
            r_regs[r_dst] <= r_res;
`endif
            zf <= (r_res == '0);
            cf <= r_cf;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign R0   = r_regs[0];
  assign R1   = r_regs[1];
  assign R2   = r_regs[2];
  assign R3   = r_regs[3];

endmodule
